// File: rtl/ex_unit_pkg.sv
// Shared encodings for the MIPS32 execute stage: ALU opcodes, result classes
// and divider FSM states.
package ex_unit_pkg;

  typedef logic [7:0] alu_op_t;
  typedef logic [2:0] alu_sel_t;

  localparam alu_op_t EXE_NOP_OP  = 8'h00;
  localparam alu_op_t EXE_AND_OP  = 8'h24;
  localparam alu_op_t EXE_OR_OP   = 8'h25;
  localparam alu_op_t EXE_XOR_OP  = 8'h26;
  localparam alu_op_t EXE_NOR_OP  = 8'h27;
  localparam alu_op_t EXE_SLL_OP  = 8'h7C;
  localparam alu_op_t EXE_SRL_OP  = 8'h02;
  localparam alu_op_t EXE_SRA_OP  = 8'h03;
  localparam alu_op_t EXE_ADDU_OP = 8'h21;
  localparam alu_op_t EXE_SUBU_OP = 8'h23;
  localparam alu_op_t EXE_SLT_OP  = 8'h2A;
  localparam alu_op_t EXE_SLTU_OP = 8'h2B;
  localparam alu_op_t EXE_DIV_OP  = 8'h1A;
  localparam alu_op_t EXE_DIVU_OP = 8'h1B;

  localparam alu_sel_t EXE_RES_NOP        = 3'b000;
  localparam alu_sel_t EXE_RES_LOGIC      = 3'b001;
  localparam alu_sel_t EXE_RES_SHIFT      = 3'b010;
  localparam alu_sel_t EXE_RES_ARITHMETIC = 3'b100;

  localparam logic [31:0] ZEROWORD   = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr = 5'd0;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_ZERO = 2'd2;
  localparam logic [1:0] DIV_DONE = 2'd3;

  function automatic logic is_div_op(input alu_op_t op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/ex_unit_div_radix2.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes,
// signs reapplied on the outputs.
module div_radix2
  import ex_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              done
);

  localparam logic [4:0] LAST_STEP = 5'(DATA_W - 1);

  logic [1:0]        r_state;
  logic [4:0]        r_cnt;
  logic [DATA_W-1:0] r_den;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_rem;
  logic              r_neg_q;
  logic              r_neg_r;

  logic              w_a_neg;
  logic              w_b_neg;
  logic [DATA_W-1:0] w_a_mag;
  logic [DATA_W-1:0] w_b_mag;
  logic [DATA_W:0]   w_trial;

  assign w_a_neg = signed_i & dividend[DATA_W-1];
  assign w_b_neg = signed_i & divisor[DATA_W-1];
  assign w_a_mag = w_a_neg ? (~dividend + 1'b1) : dividend;
  assign w_b_mag = w_b_neg ? (~divisor + 1'b1) : divisor;

  // r_quo doubles as the dividend shift register; its MSB feeds the partial remainder.
  assign w_trial = {r_rem, r_quo[DATA_W-1]} - {1'b0, r_den};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DIV_IDLE;
      r_cnt   <= '0;
      r_den   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (start) begin
            r_cnt <= '0;
            if (divisor == '0) begin
              r_state <= DIV_ZERO;
              r_quo   <= '0;
              r_rem   <= '0;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
            end else begin
              r_state <= DIV_BUSY;
              r_quo   <= w_a_mag;
              r_rem   <= '0;
              r_den   <= w_b_mag;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
            end
          end
        end
        DIV_BUSY: begin
          if (!w_trial[DATA_W]) begin
            r_rem <= w_trial[DATA_W-1:0];
            r_quo <= {r_quo[DATA_W-2:0], 1'b1};
          end else begin
            r_rem <= {r_rem[DATA_W-2:0], r_quo[DATA_W-1]};
            r_quo <= {r_quo[DATA_W-2:0], 1'b0};
          end
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == LAST_STEP) r_state <= DIV_DONE;
        end
        DIV_ZERO: r_state <= DIV_DONE;
        default:  r_state <= DIV_IDLE;
      endcase
    end
  end

  assign quotient  = r_neg_q ? (~r_quo + 1'b1) : r_quo;
  assign remainder = r_neg_r ? (~r_rem + 1'b1) : r_rem;
  assign done      = (r_state == DIV_DONE);

endmodule

// File: rtl/ex_unit.sv
// MIPS32 execute stage: decode/execute register, ALU, forwarding bus,
// execute/memory register and divide stall control.
module ex_unit
  import ex_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        aluop_i,
  input  logic [2:0]        alusel_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  output logic              ex_wreg_o,
  output logic [DATA_W-1:0] ex_wdata_o,
  output logic [4:0]        ex_wd_o,
  output logic              mem_wreg_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [4:0]        mem_wd_o,
  output logic              whilo_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              stallreq_o
);

  alu_op_t           r_aluop;
  alu_sel_t          r_alusel;
  logic [DATA_W-1:0] r_reg1;
  logic [DATA_W-1:0] r_reg2;
  logic [4:0]        r_wd;
  logic              r_wreg;

  logic              w_is_div;
  logic              w_div_done;
  logic              w_stall;
  logic [DATA_W-1:0] w_quotient;
  logic [DATA_W-1:0] w_remainder;
  logic [DATA_W-1:0] w_result;
  logic              w_wreg;

  assign w_is_div = is_div_op(r_aluop);
  assign w_stall  = w_is_div & ~w_div_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_aluop  <= EXE_NOP_OP;
      r_alusel <= EXE_RES_NOP;
      r_reg1   <= ZEROWORD;
      r_reg2   <= ZEROWORD;
      r_wd     <= NOPRegAddr;
      r_wreg   <= 1'b0;
    end else if (!w_stall) begin
      r_aluop  <= aluop_i;
      r_alusel <= alusel_i;
      r_reg1   <= reg1_i;
      r_reg2   <= reg2_i;
      r_wd     <= wd_i;
      r_wreg   <= wreg_i;
    end
  end

  div_radix2 #(.DATA_W(DATA_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (w_is_div),
    .signed_i (r_aluop == EXE_DIV_OP),
    .dividend (r_reg1),
    .divisor  (r_reg2),
    .quotient (w_quotient),
    .remainder(w_remainder),
    .done     (w_div_done)
  );

  // NOTE: every combinational output gets a default first so no path through
  // the case statements can infer a latch.
  always_comb begin
    w_result = ZEROWORD;
    w_wreg   = 1'b0;
    case (r_alusel)
      EXE_RES_LOGIC: begin
        w_wreg = r_wreg;
        case (r_aluop)
          EXE_OR_OP:  w_result = r_reg1 | r_reg2;
          EXE_AND_OP: w_result = r_reg1 & r_reg2;
          EXE_XOR_OP: w_result = r_reg1 ^ r_reg2;
          EXE_NOR_OP: w_result = ~(r_reg1 | r_reg2);
          default:    w_result = ZEROWORD;
        endcase
      end
      EXE_RES_SHIFT: begin
        w_wreg = r_wreg;
        case (r_aluop)
          EXE_SLL_OP: w_result = r_reg2 << r_reg1[4:0];
          EXE_SRL_OP: w_result = r_reg2 >> r_reg1[4:0];
          EXE_SRA_OP: w_result = $signed(r_reg2) >>> r_reg1[4:0];
          default:    w_result = ZEROWORD;
        endcase
      end
      EXE_RES_ARITHMETIC: begin
        w_wreg = r_wreg;
        case (r_aluop)
          EXE_ADDU_OP: w_result = r_reg1 + r_reg2;
          EXE_SUBU_OP: w_result = r_reg1 - r_reg2;
          EXE_SLT_OP:  w_result = {{(DATA_W-1){1'b0}}, $signed(r_reg1) < $signed(r_reg2)};
          EXE_SLTU_OP: w_result = {{(DATA_W-1){1'b0}}, r_reg1 < r_reg2};
          default:     w_result = ZEROWORD;
        endcase
      end
      default: begin
        w_result = ZEROWORD;
        w_wreg   = 1'b0;
      end
    endcase
    // Divides report through HI/LO only, whatever class decode attached.
    if (w_is_div) begin
      w_result = ZEROWORD;
      w_wreg   = 1'b0;
    end
  end

  assign ex_wreg_o  = w_wreg;
  assign ex_wdata_o = w_result;
  assign ex_wd_o    = r_wd;
  assign stallreq_o = w_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wreg_o  <= 1'b0;
      mem_wdata_o <= ZEROWORD;
      mem_wd_o    <= NOPRegAddr;
      whilo_o     <= 1'b0;
      hi_o        <= ZEROWORD;
      lo_o        <= ZEROWORD;
    end else begin
      mem_wreg_o  <= w_wreg;
      mem_wdata_o <= w_result;
      mem_wd_o    <= r_wd;
      whilo_o     <= w_is_div & w_div_done;
      if (w_is_div && w_div_done) begin
        hi_o <= w_remainder;
        lo_o <= w_quotient;
      end
    end
  end

endmodule
